// File: rtl/dram_pattern_sequencer_if.sv
// Engine-side bus between the pattern sequencer and the multi-core DRAM write/read engine.
// Latency: wires only, no storage.
// Backpressure: a request is held until the engine answers with wt_done / rd_done.
interface dram_pattern_sequencer_if #(
    parameter int NUM_CORE = 16,
    parameter int WBL_W    = 64,
    parameter int ADDR_W   = 6,
    parameter int DOUT_W   = 8
);
    logic                       io_en;
    logic [1:0]                 io_model;
    logic [ADDR_W-1:0]          wwl_add;
    logic [ADDR_W-1:0]          rwl_add;
    logic [NUM_CORE*WBL_W-1:0]  wbl_data;
    logic                       wt_done;
    logic                       rd_done;
    logic [NUM_CORE*DOUT_W-1:0] dram_data_out;

    // Sequencer side: issues requests, receives completions and read data.
    modport master (
        output io_en, io_model, wwl_add, rwl_add, wbl_data,
        input  wt_done, rd_done, dram_data_out
    );

    // Engine side: the mirror image.
    modport slave (
        input  io_en, io_model, wwl_add, rwl_add, wbl_data,
        output wt_done, rd_done, dram_data_out
    );
endinterface

// File: rtl/dram_pattern_sequencer.sv
// Sweeps a word-line range: write pattern, one idle gap, read back, compare, per address.
// Latency: per address = write wait + 1 gap + read wait + 1 compare; done pulses one cycle after the last compare.
// Backpressure: each request holds until its done input (or TIMEOUT cycles); start is ignored while busy.
module dram_pattern_sequencer #(
    parameter int NUM_CORE = 16,
    parameter int WBL_W    = 64,
    parameter int ADDR_W   = 6,
    parameter int DOUT_W   = 8,
    parameter int TIMEOUT  = 4096
) (
    input  logic                  clk_100m,
    input  logic                  rst,

    // sweep control
    input  logic                  start,
    input  logic [1:0]            pat_mode,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [ADDR_W-1:0]     end_addr,

    // engine bus
    dram_pattern_sequencer_if.master eng,

    // status
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_cnt,
    output logic [ADDR_W-1:0]     first_fail_addr,
    output logic                  fail,
    output logic                  timeout,
    output logic                  cfg_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int MIS_W = $clog2(NUM_CORE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] MODEL_IDLE = 2'b00;
    localparam logic [1:0] MODEL_WR   = 2'b01;
    localparam logic [1:0] MODEL_RD   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        GAP,
        RD,
        CMP,
        DONE
    } state_t;

    state_t                     state;
    logic [ADDR_W-1:0]          addr;
    logic [ADDR_W-1:0]          end_q;
    logic [1:0]                 mode_q;
    logic [CNT_W-1:0]           wait_cnt;
    logic [NUM_CORE*DOUT_W-1:0] rd_cap;

    logic [ADDR_W-1:0]          addr_nxt;
    logic [WBL_W-1:0]           pat_start;
    logic [WBL_W-1:0]           pat_nxt;
    logic [WBL_W-1:0]           pat_cur;
    logic [DOUT_W-1:0]          exp_byte;
    logic [MIS_W-1:0]           mism;
    logic [16:0]                err_sum;

    // One core's write word for a given mode and row. Byte modes assume WBL_W is a
    // multiple of 8; the address byte is the row zero-extended (or truncated) to 8 bits.
    function automatic logic [WBL_W-1:0] pattern_word(input logic [1:0] mode,
                                                      input logic [ADDR_W-1:0] a);
        logic [WBL_W-1:0] w;
        logic [7:0]       ab;
        ab = 8'(a);
        case (mode)
            2'b00:   w = {(WBL_W/8){8'h55}};
            2'b01:   w = {(WBL_W/8){8'hAA}};
            2'b10:   w = {(WBL_W/8){ab}};
            default: w = {{(WBL_W-1){1'b0}}, 1'b1} << (int'(a) % WBL_W);
        endcase
        return w;
    endfunction

    // Next row, write words for the first and next row, and mismatch count of the captured read.
    always_comb begin
        addr_nxt  = addr + ADDR_W'(1);
        pat_start = pattern_word(pat_mode, start_addr);
        pat_nxt   = pattern_word(mode_q, addr_nxt);
        pat_cur   = pattern_word(mode_q, addr);
        exp_byte  = pat_cur[DOUT_W-1:0];
        mism      = '0;
        for (int k = 0; k < NUM_CORE; k++) begin
            if (rd_cap[k*DOUT_W +: DOUT_W] != exp_byte) begin
                mism = mism + MIS_W'(1);
            end
        end
        err_sum = {1'b0, err_cnt} + 17'(mism);
    end

    // Sweep FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state           <= IDLE;
            addr            <= '0;
            end_q           <= '0;
            mode_q          <= 2'b00;
            wait_cnt        <= '0;
            rd_cap          <= '0;
            eng.io_en       <= 1'b0;
            eng.io_model    <= MODEL_IDLE;
            eng.wwl_add     <= '0;
            eng.rwl_add     <= '0;
            eng.wbl_data    <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_cnt         <= '0;
            first_fail_addr <= '0;
            fail            <= 1'b0;
            timeout         <= 1'b0;
            cfg_err         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy            <= 1'b1;
                        err_cnt         <= '0;
                        first_fail_addr <= '0;
                        fail            <= 1'b0;
                        timeout         <= 1'b0;
                        if (start_addr <= end_addr) begin
                            state        <= WR;
                            addr         <= start_addr;
                            end_q        <= end_addr;
                            mode_q       <= pat_mode;
                            wait_cnt     <= '0;
                            cfg_err      <= 1'b0;
                            eng.io_en    <= 1'b1;
                            eng.io_model <= MODEL_WR;
                            eng.wwl_add  <= start_addr;
                            eng.wbl_data <= {NUM_CORE{pat_start}};
                        end else begin
                            // Empty range: report and finish without touching the engine.
                            state   <= DONE;
                            done    <= 1'b1;
                            cfg_err <= 1'b1;
                        end
                    end
                end

                WR: begin
                    if (eng.wt_done) begin
                        state        <= GAP;
                        eng.io_en    <= 1'b0;
                        eng.io_model <= MODEL_IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        state        <= DONE;
                        done         <= 1'b1;
                        timeout      <= 1'b1;
                        eng.io_en    <= 1'b0;
                        eng.io_model <= MODEL_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                GAP: begin
                    state        <= RD;
                    wait_cnt     <= '0;
                    eng.io_en    <= 1'b1;
                    eng.io_model <= MODEL_RD;
                    eng.rwl_add  <= addr;
                end

                RD: begin
                    if (eng.rd_done) begin
                        state        <= CMP;
                        rd_cap       <= eng.dram_data_out;
                        eng.io_en    <= 1'b0;
                        eng.io_model <= MODEL_IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        state        <= DONE;
                        done         <= 1'b1;
                        timeout      <= 1'b1;
                        eng.io_en    <= 1'b0;
                        eng.io_model <= MODEL_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                CMP: begin
                    err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
                    // Only the first failing row is remembered.
                    if ((mism != '0) && !fail) begin
                        fail            <= 1'b1;
                        first_fail_addr <= addr;
                    end
                    // Compare against the latched end first so end = all-ones never wraps.
                    if (addr == end_q) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state        <= WR;
                        addr         <= addr_nxt;
                        wait_cnt     <= '0;
                        eng.io_en    <= 1'b1;
                        eng.io_model <= MODEL_WR;
                        eng.wwl_add  <= addr_nxt;
                        eng.wbl_data <= {NUM_CORE{pat_nxt}};
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_pattern_sequencer.sv
// Bench for dram_pattern_sequencer: loopback engine model with per-row/core read corruption.
// Expected write words, error counts and first-fail rows come from a plain reference of the pattern rules.
// Engine answer latency is programmable; read or write completions can be withheld.
module tb_dram_pattern_sequencer;
    localparam int NC = 16;
    localparam int WW = 64;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk_100m = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    pat_mode = 2'b00;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic          busy, done, fail, timeout, cfg_err;
    logic [15:0]   err_cnt;
    logic [AW-1:0] first_fail_addr;

    dram_pattern_sequencer_if #(.NUM_CORE(NC), .WBL_W(WW), .ADDR_W(AW), .DOUT_W(DW)) bus ();

    dram_pattern_sequencer #(
        .NUM_CORE(NC), .WBL_W(WW), .ADDR_W(AW), .DOUT_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk_100m(clk_100m), .rst(rst), .start(start), .pat_mode(pat_mode),
        .start_addr(start_addr), .end_addr(end_addr), .eng(bus),
        .busy(busy), .done(done), .err_cnt(err_cnt), .first_fail_addr(first_fail_addr),
        .fail(fail), .timeout(timeout), .cfg_err(cfg_err)
    );

    always #5 clk_100m = ~clk_100m;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    logic [7:0] mem  [64][NC];
    logic [7:0] corr [64][NC];
    int lat = 5;
    bit wt_hold = 1'b0, rd_hold = 1'b0, spur = 1'b0;

    int                 wr_addr_q[$];
    logic [WW*NC-1:0]   wr_data_q[$];
    int                 wr_done_cyc_q[$];
    int                 rd_addr_q[$];
    int                 rd_start_cyc_q[$];
    int unstable = 0, done_cnt = 0, io_en_cnt = 0, rd_cyc_cnt = 0, done_cyc = 0;
    int busy_bad = 0, model_bad = 0;

    always @(posedge clk_100m) cyc <= cyc + 1;

    // Cycle monitor: request/done activity and bus-level invariants.
    always @(negedge clk_100m) begin
        if (bus.io_en) io_en_cnt++;
        if (bus.io_en && bus.io_model == 2'b10) rd_cyc_cnt++;
        if (bus.io_en && !busy) busy_bad++;
        if (!rst && !bus.io_en && bus.io_model != 2'b00) model_bad++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Loopback engine: stores written bytes, returns them XOR the corruption table.
    initial begin : engine
        logic [AW-1:0]    a;
        logic [WW*NC-1:0] d;
        bus.wt_done = 1'b0;
        bus.rd_done = 1'b0;
        bus.dram_data_out = '0;
        forever begin
            @(negedge clk_100m);
            if (!rst && bus.io_en && bus.io_model == 2'b01 && !wt_hold) begin
                a = bus.wwl_add;
                d = bus.wbl_data;
                wr_addr_q.push_back(int'(a));
                wr_data_q.push_back(d);
                for (int i = 1; i <= lat; i++) begin
                    @(negedge clk_100m);
                    if (!(bus.io_en && bus.io_model == 2'b01 && bus.wwl_add == a && bus.wbl_data == d))
                        unstable++;
                    bus.rd_done = spur && (i == 1) && (lat > 1);
                end
                bus.rd_done = 1'b0;
                bus.wt_done = 1'b1;
                for (int k = 0; k < NC; k++) mem[a][k] = d[k*WW +: 8];
                wr_done_cyc_q.push_back(cyc);
                @(negedge clk_100m);
                bus.wt_done = 1'b0;
            end else if (!rst && bus.io_en && bus.io_model == 2'b10 && !rd_hold) begin
                a = bus.rwl_add;
                rd_addr_q.push_back(int'(a));
                rd_start_cyc_q.push_back(cyc);
                for (int i = 1; i <= lat; i++) begin
                    @(negedge clk_100m);
                    if (!(bus.io_en && bus.io_model == 2'b10 && bus.rwl_add == a)) unstable++;
                    bus.wt_done = spur && (i == 1) && (lat > 1);
                end
                bus.wt_done = 1'b0;
                for (int k = 0; k < NC; k++) bus.dram_data_out[k*DW +: DW] = mem[a][k] ^ corr[a][k];
                bus.rd_done = 1'b1;
                @(negedge clk_100m);
                bus.rd_done = 1'b0;
                bus.dram_data_out = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk_100m);
            #1;
        end
    endtask

    // Reference per-core write word, straight from the pattern rules.
    function automatic logic [63:0] ref_word(input logic [1:0] m, input int a);
        case (m)
            2'b00:   return 64'h5555_5555_5555_5555;
            2'b01:   return 64'hAAAA_AAAA_AAAA_AAAA;
            2'b10:   return {8{8'(a)}};
            default: return 64'd1 << (a % 64);
        endcase
    endfunction

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_done_cyc_q.delete();
        rd_addr_q.delete(); rd_start_cyc_q.delete();
        unstable = 0; done_cnt = 0; io_en_cnt = 0; rd_cyc_cnt = 0;
        busy_bad = 0; model_bad = 0;
    endtask

    task automatic clear_corr();
        for (int a = 0; a < 64; a++)
            for (int k = 0; k < NC; k++) corr[a][k] = 8'h00;
    endtask

    // Launch a sweep, then scramble the inputs so only latched values can matter.
    task automatic pulse_start(input logic [1:0] m, input int s, input int e);
        @(negedge clk_100m); #1;
        pat_mode = m; start_addr = AW'(s); end_addr = AW'(e); start = 1'b1;
        start_cyc = cyc;
        tick(1);
        start = 1'b0;
        pat_mode = 2'($urandom); start_addr = AW'($urandom); end_addr = AW'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin
            tick(1);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
        tick(3);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_io_en"}, 64'(bus.io_en), 64'd0);
        chk({tag, "_io_model"}, 64'(bus.io_model), 64'd0);
        chk({tag, "_wwl_add"}, 64'(bus.wwl_add), 64'd0);
        chk({tag, "_rwl_add"}, 64'(bus.rwl_add), 64'd0);
        chk({tag, "_wbl_data_or"}, 64'(|bus.wbl_data), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
        chk({tag, "_fail"}, 64'(fail), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
        chk({tag, "_cfg_err"}, 64'(cfg_err), 64'd0);
        chk({tag, "_ffa"}, 64'(first_fail_addr), 64'd0);
    endtask

    // Full check of a completed normal sweep against the reference.
    task automatic check_sweep(input string tag, input logic [1:0] m, input int s, input int e);
        int n = e - s + 1;
        int exp_err = 0;
        int exp_ffa = -1;
        logic [WW*NC-1:0] d;
        logic [63:0] diff;
        for (int a = s; a <= e; a++)
            for (int k = 0; k < NC; k++)
                if (corr[a][k] != 8'h00) begin
                    exp_err++;
                    if (exp_ffa < 0) exp_ffa = a;
                end
        if (exp_ffa < 0) exp_ffa = 0;
        chk({tag, "_wr_count"}, 64'(wr_addr_q.size()), 64'(n));
        chk({tag, "_rd_count"}, 64'(rd_addr_q.size()), 64'(n));
        for (int i = 0; i < n && i < wr_addr_q.size() && i < rd_addr_q.size(); i++) begin
            chk({tag, "_wr_addr"}, 64'(wr_addr_q[i]), 64'(s + i));
            chk({tag, "_rd_addr"}, 64'(rd_addr_q[i]), 64'(s + i));
            d = wr_data_q[i];
            diff = '0;
            for (int k = 0; k < NC; k++) diff = diff | (d[k*WW +: WW] ^ ref_word(m, s + i));
            chk({tag, "_wr_data_diff"}, diff, 64'd0);
            chk({tag, "_gap"}, 64'(rd_start_cyc_q[i] - wr_done_cyc_q[i]), 64'd2);
        end
        chk({tag, "_unstable"}, 64'(unstable), 64'd0);
        chk({tag, "_busy_bad"}, 64'(busy_bad), 64'd0);
        chk({tag, "_model_bad"}, 64'(model_bad), 64'd0);
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
        chk({tag, "_fail"}, 64'(fail), 64'(exp_err != 0));
        chk({tag, "_ffa"}, 64'(first_fail_addr), 64'(exp_ffa));
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
        chk({tag, "_cfg_err"}, 64'(cfg_err), 64'd0);
    endtask

    initial begin : stim
        int s, e, snap;
        logic [1:0] m;
        clear_corr();

        // Reset state.
        tick(3);
        check_reset_state("rst0");
        rst = 1'b0;
        tick(2);

        // Mode 00 over 0..3, five-cycle engine, clean loopback.
        clear_logs(); lat = 5; spur = 1'b0;
        pulse_start(2'b00, 0, 3);
        wait_done("m00");
        check_sweep("m00", 2'b00, 0, 3);

        // Mode 10 over 2..4, core 3 reads back 0x00 at row 3.
        clear_logs(); clear_corr(); lat = 3;
        corr[3][3] = 8'h03;
        pulse_start(2'b10, 2, 4);
        wait_done("m10");
        check_sweep("m10", 2'b10, 2, 4);
        tick(5);
        chk("m10_hold_err", 64'(err_cnt), 64'd1);
        chk("m10_hold_ffa", 64'(first_fail_addr), 64'd3);
        rst = 1'b1;
        tick(1);
        check_reset_state("rst_after_fail");
        rst = 1'b0;
        tick(2);

        // Walking one at the top of the row space; must stop at 63.
        clear_logs(); clear_corr(); lat = 2;
        pulse_start(2'b11, 62, 63);
        wait_done("m11");
        check_sweep("m11", 2'b11, 62, 63);
        snap = io_en_cnt;
        tick(20);
        chk("m11_no_wrap", 64'(io_en_cnt), 64'(snap));

        // Empty range.
        clear_logs();
        pulse_start(2'b01, 5, 2);
        wait_done("cfg");
        chk("cfg_err", 64'(cfg_err), 64'd1);
        chk("cfg_io_en_cnt", 64'(io_en_cnt), 64'd0);
        chk("cfg_done_lat", 64'(done_cyc - start_cyc), 64'd1);
        chk("cfg_done_cnt", 64'(done_cnt), 64'd1);
        chk("cfg_busy", 64'(busy), 64'd0);

        // Randomized sweeps; the first also gets an ignored start while busy.
        for (int it = 0; it < 6; it++) begin
            clear_logs(); clear_corr();
            m = 2'($urandom);
            s = int'($urandom_range(0, 63));
            e = s + int'($urandom_range(0, 4));
            if (e > 63) e = 63;
            lat = (it == 0) ? 4 : int'($urandom_range(1, 8));
            spur = 1'($urandom);
            for (int a = s; a <= e; a++)
                if ($urandom_range(0, 2) == 0)
                    corr[a][$urandom_range(0, NC - 1)] = 8'(int'($urandom_range(1, 255)));
            pulse_start(m, s, e);
            if (it == 0) begin
                tick(2);
                start = 1'b1; pat_mode = ~m; start_addr = '0; end_addr = '0;
                tick(1);
                start = 1'b0;
            end
            wait_done("rnd");
            check_sweep("rnd", m, s, e);
        end
        spur = 1'b0;

        // Read completion withheld: timeout after exactly TO read cycles.
        clear_logs(); clear_corr(); lat = 3; rd_hold = 1'b1;
        pulse_start(2'b10, 10, 12);
        wait_done("tmo");
        chk("tmo_timeout", 64'(timeout), 64'd1);
        chk("tmo_rd_cycles", 64'(rd_cyc_cnt), 64'(TO));
        chk("tmo_io_en", 64'(bus.io_en), 64'd0);
        chk("tmo_done_cnt", 64'(done_cnt), 64'd1);
        chk("tmo_wr_count", 64'(wr_addr_q.size()), 64'd1);
        chk("tmo_busy", 64'(busy), 64'd0);
        rd_hold = 1'b0;

        // Reset during a write wait, with an ignored start just before it.
        clear_logs(); wt_hold = 1'b1;
        pulse_start(2'b00, 5, 9);
        tick(4);
        chk("rstmid_busy", 64'(busy), 64'd1);
        chk("rstmid_io_en", 64'(bus.io_en), 64'd1);
        start = 1'b1; start_addr = 6'd7; end_addr = 6'd7;
        tick(1);
        start = 1'b0;
        rst = 1'b1;
        tick(1);
        check_reset_state("rst_mid");
        rst = 1'b0; wt_hold = 1'b0;
        io_en_cnt = 0; done_cnt = 0;
        tick(30);
        chk("rstmid_no_sweep", 64'(io_en_cnt), 64'd0);
        chk("rstmid_no_done", 64'(done_cnt), 64'd0);
        chk("rstmid_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
